// File: rtl/disp_mux_bcd.sv
// Four-digit multiplexed seven-segment driver for BCD inputs.
// Inputs are latched once per frame; all outputs are registered.

module disp_mux_bcd_dec (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  // Active-low {g,f,e,d,c,b,a}; codes above 9 show a dash.
  always_comb begin
    seg = 7'b0111111;
    unique case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  end
endmodule

module disp_mux_bcd #(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dp_in,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);
  localparam int NUM_DIGITS = 4;
  localparam logic [REFRESH_BITS-1:0] P_ONE = REFRESH_BITS'(1);

  logic [REFRESH_BITS-1:0]           p;
  logic [1:0]                        idx, idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]        shd, shd_nxt, digs;
  logic [NUM_DIGITS-1:0]             sdp, sdp_nxt;
  logic [NUM_DIGITS-1:0][6:0]        seg_raw;
  logic [NUM_DIGITS-1:0]             blank;
  logic                              wrap, snap;
  logic [3:0]                        an_nxt;
  logic [7:0]                        sseg_nxt;

  assign digs    = {dig3, dig2, dig1, dig0};
  assign wrap    = &p;
  assign snap    = wrap && (idx == 2'd3);
  assign idx_nxt = wrap ? idx + 2'd1 : idx;
  assign shd_nxt = snap ? digs  : shd;
  assign sdp_nxt = snap ? dp_in : sdp;

  // Outputs are decoded from next-state values so they line up with idx.
  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_dec
      disp_mux_bcd_dec u_dec (.bcd(shd_nxt[i]), .seg(seg_raw[i]));
    end
  endgenerate

  // A digit blanks only if it is zero and every digit to its left blanked.
  always_comb begin
    blank    = '0;
    blank[3] = blank_lz && (shd_nxt[3] == 4'd0);
    blank[2] = blank[3] && (shd_nxt[2] == 4'd0);
    blank[1] = blank[2] && (shd_nxt[1] == 4'd0);
    blank[0] = 1'b0;
  end

  always_comb begin
    an_nxt   = ~(4'b0001 << idx_nxt);
    sseg_nxt = {~sdp_nxt[idx_nxt], blank[idx_nxt] ? 7'h7F : seg_raw[idx_nxt]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p          <= '1;
      idx        <= 2'd3;
      shd        <= '0;
      sdp        <= '0;
      an         <= 4'hF;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      p          <= p + P_ONE;
      idx        <= idx_nxt;
      shd        <= shd_nxt;
      sdp        <= sdp_nxt;
      an         <= an_nxt;
      sseg       <= sseg_nxt;
      frame_tick <= snap;
    end
  end
endmodule

// File: tb/tb_disp_mux_bcd.sv
// Bench for disp_mux_bcd at REFRESH_BITS=2 (4-cycle slot, 16-cycle frame).
// A frame-level model is checked every cycle alongside directed literals.

module tb_disp_mux_bcd;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3, dp_in;
  logic       blank_lz;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  int vectors = 0;
  int errors  = 0;

  disp_mux_bcd #(.REFRESH_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dp_in(dp_in), .blank_lz(blank_lz),
    .an(an), .sseg(sseg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mt counts edges since reset release; snapshot at every 16th.
  int         mt = -1;
  logic [3:0] ms [4] = '{default: 4'd0};
  logic [3:0] msdp = 4'd0;
  logic       mblz = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mt <= -1;
      for (int k = 0; k < 4; k++) ms[k] <= 4'd0;
      msdp <= 4'd0;
      mblz <= 1'b0;
    end else begin
      mt   <= mt + 1;
      mblz <= blank_lz;
      if ((mt + 1) % 16 == 0) begin
        ms[0] <= dig0; ms[1] <= dig1; ms[2] <= dig2; ms[3] <= dig3;
        msdp  <= dp_in;
      end
    end
  end

  function automatic logic [7:0] model_seg(input int d);
    logic [6:0] g;
    bit         bl;
    case (ms[d])
      4'd0: g = 7'b1000000;  4'd1: g = 7'b1111001;
      4'd2: g = 7'b0100100;  4'd3: g = 7'b0110000;
      4'd4: g = 7'b0011001;  4'd5: g = 7'b0010010;
      4'd6: g = 7'b0000010;  4'd7: g = 7'b1111000;
      4'd8: g = 7'b0000000;  4'd9: g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    bl = mblz && (d != 0);
    for (int j = d; j <= 3; j++) if (ms[j] != 4'd0) bl = 1'b0;
    return {~msdp[d], bl ? 7'h7F : g};
  endfunction

  always @(negedge clk) begin
    int         d;
    logic [3:0] ea;
    logic       eft;
    if (mt < 0) begin
      chk("model_rst_an", {4'h0, an}, 8'h0F);
      chk("model_rst_sseg", sseg, 8'hFF);
      chk("model_rst_ft", {7'h0, frame_tick}, 8'h00);
    end else begin
      d   = (mt / 4) % 4;
      ea  = ~(4'b0001 << d);
      eft = (mt % 16 == 0);
      chk("model_an", {4'h0, an}, {4'h0, ea});
      chk("model_sseg", sseg, model_seg(d));
      chk("model_ft", {7'h0, frame_tick}, {7'h0, eft});
    end
  end

  task automatic next_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    chk("frame_tick_seen", {7'h0, frame_tick}, 8'h01);
  endtask

  task automatic apply(input logic [3:0] d3, d2, d1, d0, dp, input logic blz);
    dig3 = d3; dig2 = d2; dig1 = d1; dig0 = d0; dp_in = dp; blank_lz = blz;
  endtask

  // Returns sseg per digit over one full frame starting at the next snapshot.
  task automatic grab(output logic [3:0][7:0] g);
    next_frame();
    g[0] = sseg;
    for (int k = 1; k < 4; k++) begin
      repeat (4) @(negedge clk);
      g[k] = sseg;
    end
  endtask

  initial begin
    logic [3:0][7:0] g;
    apply(4, 3, 2, 1, 4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_sseg", sseg, 8'hFF);
    chk("rst_ft", {7'h0, frame_tick}, 8'h00);

    reset_n = 1'b1;
    @(negedge clk);
    chk("first_an", {4'h0, an}, 8'h0E);
    chk("first_sseg", sseg, 8'hF9);
    chk("first_ft", {7'h0, frame_tick}, 8'h01);
    @(negedge clk);
    chk("ft_one_cycle", {7'h0, frame_tick}, 8'h00);

    repeat (3) @(negedge clk);
    chk("scan1_an", {4'h0, an}, 8'h0D);  chk("scan1_sseg", sseg, 8'hA4);
    repeat (4) @(negedge clk);
    chk("scan2_an", {4'h0, an}, 8'h0B);  chk("scan2_sseg", sseg, 8'hB0);
    repeat (4) @(negedge clk);
    chk("scan3_an", {4'h0, an}, 8'h07);  chk("scan3_sseg", sseg, 8'h99);
    repeat (4) @(negedge clk);
    chk("scan4_an", {4'h0, an}, 8'h0E);  chk("scan4_sseg", sseg, 8'hF9);
    chk("scan4_ft", {7'h0, frame_tick}, 8'h01);

    // Asynchronous reset in the middle of a frame.
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_an", {4'h0, an}, 8'h0F);
    chk("async_sseg", sseg, 8'hFF);
    chk("async_ft", {7'h0, frame_tick}, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rerun_an", {4'h0, an}, 8'h0E);
    chk("rerun_sseg", sseg, 8'hF9);
    chk("rerun_ft", {7'h0, frame_tick}, 8'h01);

    // Input change mid-frame must wait for the next snapshot.
    repeat (3) @(negedge clk);
    chk("snap_hold", sseg, 8'hF9);
    repeat (2) @(negedge clk);
    dig0 = 4'd7;
    next_frame();
    chk("snap_new", sseg, 8'hF8);

    apply(0, 0, 5, 0, 4'b0000, 1'b1);  grab(g);
    chk("lz1_d3", g[3], 8'hFF); chk("lz1_d2", g[2], 8'hFF);
    chk("lz1_d1", g[1], 8'h92); chk("lz1_d0", g[0], 8'hC0);
    apply(0, 0, 0, 0, 4'b0000, 1'b1);  grab(g);
    chk("lz2_d3", g[3], 8'hFF); chk("lz2_d2", g[2], 8'hFF);
    chk("lz2_d1", g[1], 8'hFF); chk("lz2_d0", g[0], 8'hC0);
    apply(0, 0, 0, 0, 4'b0000, 1'b0);  grab(g);
    chk("nolz_d3", g[3], 8'hC0); chk("nolz_d2", g[2], 8'hC0);
    chk("nolz_d1", g[1], 8'hC0); chk("nolz_d0", g[0], 8'hC0);
    apply(0, 12, 0, 0, 4'b0000, 1'b1); grab(g);
    chk("inv_d3", g[3], 8'hFF); chk("inv_d2", g[2], 8'hBF);
    chk("inv_d1", g[1], 8'hC0); chk("inv_d0", g[0], 8'hC0);

    apply(0, 12, 0, 0, 4'b0100, 1'b0); grab(g);
    chk("dp_inv_on", g[2], 8'h3F);
    apply(0, 12, 0, 0, 4'b0000, 1'b0); grab(g);
    chk("dp_inv_off", g[2], 8'hBF);
    apply(0, 0, 0, 0, 4'b1000, 1'b1);  grab(g);
    chk("dp_blank_d3", g[3], 8'h7F);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end
endmodule
